// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian words into instruction
// memory and holds the core in reset until a checksum-valid image is in place.
module prog_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [15:0]           words_loaded
);

  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           asm_q, asm_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [15:0]           words_q, words_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  ready_q, done_q, err_q, crst_q;
  logic                  in_load, accept;
  logic [16:0]           n_full;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    in_load = (state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK});
    accept  = byte_valid && in_load;
    n_full  = {1'b0, byte_data, len_q[7:0]};

    if (in_load) tmo_d = accept ? '0 : tmo_q + TW'(1);

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_LO;
          words_d = '0;
          csum_d  = '0;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = byte_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = byte_data;
          if (n_full > CAPACITY)  state_d = S_ERROR;
          else if (n_full == '0)  state_d = S_CHECK;
          else                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          // Shift right so the first (least-significant) byte ends up in [7:0].
          asm_d  = {byte_data, asm_q[31:8]};
          csum_d = csum_q ^ byte_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_q[ADDR_WIDTH-1:0];
            wdata_d = asm_d;
            words_d = words_q + 16'd1;
            if (({1'b0, words_q} + 17'd1) == {1'b0, len_q}) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    // An accepted byte on the limit cycle takes priority over the timeout.
    if (in_load && !accept && tmo_q == TW'(TIMEOUT_CYCLES - 1)) state_d = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= (state_d inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK});
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERROR);
      crst_q  <= (state_d != S_DONE);
    end
  end

  // The word assembler is pure data and is always fully refilled before use.
  always_ff @(posedge clk) asm_q <= asm_d;

  assign byte_ready   = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_rst     = crst_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: nominal/bad-checksum loads, length limits,
// timeout boundary, gapped stream, mid-load reset and full-capacity image.
module tb_prog_loader;
  localparam int AW = 10;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready, imem_we, core_rst, load_done, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [15:0]   words_loaded;

  int tests = 0;
  int fails = 0;
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  prog_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  // All tasks start and end on a negedge; a byte driven there transfers on
  // the following posedge, so consecutive calls stream back-to-back.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL send_byte: byte_ready=%b required 1 within 50 cycles", byte_ready);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_writes();
    wa.delete();
    wd.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL reset byte_ready: got %b want 0", byte_ready); end
    tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset imem_we: got %b want 0", imem_we); end
    tests++; if (imem_addr !== '0) begin fails++; $display("FAIL reset imem_addr: got %h want 0", imem_addr); end
    tests++; if (imem_wdata !== 32'h0) begin fails++; $display("FAIL reset imem_wdata: got %h want 0", imem_wdata); end
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL reset core_rst: got %b want 1", core_rst); end
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset load_done: got %b want 0", load_done); end
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset load_err: got %b want 0", load_err); end
    tests++; if (words_loaded !== 16'd0) begin fails++; $display("FAIL reset words_loaded: got %0d want 0", words_loaded); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Data bytes 13 00 00 00 93 00 10 00 XOR to 0x90.
  task automatic send_nominal(input logic [7:0] chk);
    logic [7:0] s[10];
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_writes();
    pulse_start();
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL start core_rst: got %b want 1", core_rst); end
    for (int i = 0; i < 10; i++) send_byte(s[i]);
    tests++; if (imem_we !== 1'b1 || byte_ready !== 1'b1) begin fails++; $display("FAIL last write cycle: we=%b ready=%b want 1 1", imem_we, byte_ready); end
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL pre-check core_rst: got %b want 1", core_rst); end
    send_byte(chk);
    tests++;
    if (wa.size() != 2) begin
      fails++; $display("FAIL nominal write count: got %0d want 2", wa.size());
    end else if (wa[0] !== 10'd0 || wd[0] !== 32'h00000013 || wa[1] !== 10'd1 || wd[1] !== 32'h00100093) begin
      fails++; $display("FAIL nominal writes: got %h:%h %h:%h want 000:00000013 001:00100093", wa[0], wd[0], wa[1], wd[1]);
    end
    tests++; if (words_loaded !== 16'd2) begin fails++; $display("FAIL nominal words_loaded: got %0d want 2", words_loaded); end
  endtask

  task automatic test_nominal();
    send_nominal(8'h90);
    tests++; if (load_done !== 1'b1 || core_rst !== 1'b0 || load_err !== 1'b0) begin fails++; $display("FAIL nominal done: done=%b core_rst=%b err=%b want 1 0 0", load_done, core_rst, load_err); end
  endtask

  task automatic test_bad_checksum();
    send_nominal(8'h81);
    tests++; if (load_err !== 1'b1 || core_rst !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL badsum: err=%b core_rst=%b done=%b want 1 1 0", load_err, core_rst, load_done); end
  endtask

  task automatic test_overflow();
    clear_writes();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h04);
    tests++; if (load_err !== 1'b1 || byte_ready !== 1'b0) begin fails++; $display("FAIL overflow: err=%b ready=%b want 1 0", load_err, byte_ready); end
    repeat (5) @(negedge clk);
    tests++; if (wa.size() != 0) begin fails++; $display("FAIL overflow writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_zero_len();
    clear_writes();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    tests++; if (load_done !== 1'b1 || core_rst !== 1'b0 || wa.size() != 0) begin fails++; $display("FAIL zero len ok: done=%b core_rst=%b writes=%0d want 1 0 0", load_done, core_rst, wa.size()); end
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    tests++; if (load_err !== 1'b1 || core_rst !== 1'b1 || wa.size() != 0) begin fails++; $display("FAIL zero len bad: err=%b core_rst=%b writes=%0d want 1 1 0", load_err, core_rst, wa.size()); end
  endtask

  task automatic test_timeout();
    int n = 0;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    while (load_err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++; if (n != TO) begin fails++; $display("FAIL timeout latency: got %0d cycles want %0d", n, TO); end
    tests++; if (core_rst !== 1'b1 || byte_ready !== 1'b0) begin fails++; $display("FAIL timeout state: core_rst=%b ready=%b want 1 0", core_rst, byte_ready); end
  endtask

  task automatic test_gaps();
    logic [31:0] w[3];
    logic [7:0]  b, chk;
    int          k;
    w = '{32'hDEADBEEF, 32'h01234567, 32'h000000FF};
    chk = 8'h00;
    k = 0;
    clear_writes();
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = w[i][8*j +: 8];
        chk = chk ^ b;
        if (k == 1) begin
          // A gap of TO-1 idle cycles lands the byte on the limit cycle; the
          // start pulse inside it must be ignored mid-load.
          pulse_start();
          repeat (TO - 2) @(negedge clk);
        end else begin
          repeat ($urandom_range(0, TO - 1)) @(negedge clk);
        end
        send_byte(b);
        k++;
      end
    end
    repeat ($urandom_range(0, TO - 1)) @(negedge clk);
    send_byte(chk);
    tests++; if (load_done !== 1'b1 || load_err !== 1'b0) begin fails++; $display("FAIL gaps result: done=%b err=%b want 1 0", load_done, load_err); end
    tests++;
    if (wa.size() != 3) begin
      fails++; $display("FAIL gaps write count: got %0d want 3", wa.size());
    end else if (wd[0] !== w[0] || wd[1] !== w[1] || wd[2] !== w[2] || wa[2] !== 10'd2) begin
      fails++; $display("FAIL gaps data: got %h %h %h @%0d want %h %h %h @2", wd[0], wd[1], wd[2], wa[2], w[0], w[1], w[2]);
    end
  endtask

  task automatic test_reset_mid_data();
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (byte_ready !== 1'b0 || core_rst !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin fails++; $display("FAIL midreset ctrl: ready=%b core_rst=%b done=%b err=%b want 0 1 0 0", byte_ready, core_rst, load_done, load_err); end
    tests++; if (words_loaded !== 16'd0) begin fails++; $display("FAIL midreset words_loaded: got %0d want 0", words_loaded); end
    repeat (3) @(negedge clk);
    tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL midreset idle: ready=%b want 0", byte_ready); end
  endtask

  task automatic test_full_capacity();
    logic [31:0] word;
    logic [7:0]  chk;
    int          bad;
    chk = 8'h00;
    bad = 0;
    clear_writes();
    pulse_start();
    send_byte(8'h00); send_byte(8'h04);
    for (int i = 0; i < 1024; i++) begin
      word = 32'hC0DE0000 | i;
      for (int j = 0; j < 4; j++) begin
        chk = chk ^ word[8*j +: 8];
        send_byte(word[8*j +: 8]);
      end
    end
    send_byte(chk);
    repeat (3) @(negedge clk);
    tests++; if (load_done !== 1'b1 || core_rst !== 1'b0) begin fails++; $display("FAIL full done: done=%b core_rst=%b want 1 0", load_done, core_rst); end
    tests++; if (words_loaded !== 16'd1024) begin fails++; $display("FAIL full words_loaded: got %0d want 1024", words_loaded); end
    tests++; if (wa.size() != 1024) begin fails++; $display("FAIL full write count: got %0d want 1024", wa.size()); end
    for (int i = 0; i < wa.size(); i++) begin
      word = 32'hC0DE0000 | i;
      if (wa[i] !== AW'(i) || wd[i] !== word) bad++;
    end
    tests++; if (bad != 0 || wa.size() == 0 || wa[wa.size()-1] !== 10'h3FF) begin fails++; $display("FAIL full writes: %0d bad entries, last addr %h want 0 and 3ff", bad, (wa.size() == 0) ? 10'h0 : wa[wa.size()-1]); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_overflow();
    test_zero_len();
    test_timeout();
    test_gaps();
    test_reset_mid_data();
    test_full_capacity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
